// File: rtl/sram_byte_streamer.sv
// sram_byte_streamer: reads consecutive SRAM words and hands them out one
// byte lane at a time over a valid/ready link, with optional block pauses,
// a frame-length stop and a synchronous restart.
module sram_byte_streamer #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BYTE_W      = 8,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned TOTAL_BYTES = 200000,
  parameter int unsigned PAUSE_WORDS = 512,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned MSB_FIRST   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              restart,
  input  logic              resume,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_sel,
  output logic              sram_rd,
  output logic              sram_wr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              pause,
  output logic              finish,
  output logic [CNT_W-1:0]  byte_count
);

  localparam int unsigned N      = DATA_W / BYTE_W;
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  // Divisor kept non-zero so the modulo stays legal when pausing is disabled.
  localparam int unsigned PW_DIV = (PAUSE_WORDS == 0) ? 1 : PAUSE_WORDS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EMIT,
    S_PAUSE,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [CNT_W-1:0]   cnt_d;

  // Picks the byte lane for output position i according to the byte order.
  function automatic logic [BYTE_W-1:0] lane_sel(input logic [DATA_W-1:0] w,
                                                 input logic [IDX_W-1:0]  i);
    int unsigned lane;
    lane = (MSB_FIRST != 0) ? (N - 32'd1 - 32'(i)) : 32'(i);
    return BYTE_W'(w >> (lane * BYTE_W));
  endfunction

  assign sram_wr = 1'b0;

  // Next-state and datapath update; restart overrides everything else.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    word_d  = word_q;
    addr_d  = sram_addr;
    cnt_d   = byte_count;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_READ;
      end
      S_READ: begin
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          word_d  = sram_rdata;
          idx_d   = '0;
          lat_d   = '0;
          state_d = S_EMIT;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          cnt_d = byte_count + CNT_W'(1);
          idx_d = idx_q + IDX_W'(1);
          if (cnt_d == CNT_W'(TOTAL_BYTES)) begin
            state_d = S_FINISH;
          end else if (idx_q == IDX_W'(N - 1)) begin
            idx_d  = '0;
            addr_d = sram_addr + ADDR_W'(1);
            if ((PAUSE_WORDS != 0) && ((32'(addr_d) % PW_DIV) == 32'd0))
              state_d = S_PAUSE;
            else if (start)
              state_d = S_READ;
            else
              state_d = S_IDLE;
          end
        end
      end
      S_PAUSE: begin
        if (resume) state_d = start ? S_READ : S_IDLE;
      end
      S_FINISH: begin
        state_d = S_FINISH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (restart) begin
      state_d = S_IDLE;
      idx_d   = '0;
      lat_d   = '0;
      addr_d  = '0;
      cnt_d   = '0;
    end
  end

  // State, datapath and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      lat_q      <= '0;
      word_q     <= '0;
      sram_addr  <= '0;
      byte_count <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      sram_sel   <= 1'b0;
      sram_rd    <= 1'b0;
      pause      <= 1'b0;
      finish     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      word_q     <= word_d;
      sram_addr  <= addr_d;
      byte_count <= cnt_d;
      out_data   <= lane_sel(word_d, idx_d);
      out_valid  <= (state_d == S_EMIT);
      sram_sel   <= (state_d == S_READ);
      sram_rd    <= (state_d == S_READ);
      pause      <= (state_d == S_PAUSE);
      finish     <= (state_d == S_FINISH);
    end
  end

endmodule

// File: tb/tb_sram_byte_streamer.sv
// Scoreboard bench: three streamer configurations (pause/wrap, short frame
// with restart, wide little-endian word with slow SRAM and backpressure).
module tb_sram_byte_streamer;

  logic clk;
  logic rst_n;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- DUT A: 16/8, ADDR_W=3, 20 bytes, pause every 4 words
  logic        start_a = 0, restart_a = 0, resume_a = 0, out_ready_a = 0;
  logic [7:0]  out_data_a;
  logic        out_valid_a, sram_sel_a, sram_rd_a, sram_wr_a, pause_a, finish_a;
  logic [2:0]  sram_addr_a;
  logic [15:0] rdata_a;
  logic [19:0] byte_count_a;

  // ---------------- DUT B: defaults with TOTAL_BYTES=5
  logic        start_b = 0, restart_b = 0, resume_b = 0, out_ready_b = 0;
  logic [7:0]  out_data_b;
  logic        out_valid_b, sram_sel_b, sram_rd_b, sram_wr_b, pause_b, finish_b;
  logic [18:0] sram_addr_b;
  logic [15:0] rdata_b;
  logic [19:0] byte_count_b;

  // ---------------- DUT C: 32/8, RD_LAT=3, LSB first, no pausing
  logic        start_c = 0, restart_c = 0, resume_c = 0, out_ready_c = 0;
  logic [7:0]  out_data_c;
  logic        out_valid_c, sram_sel_c, sram_rd_c, sram_wr_c, pause_c, finish_c;
  logic [18:0] sram_addr_c;
  logic [31:0] rdata_c;
  logic [19:0] byte_count_c;

  logic [15:0] mem_a [8];
  logic [7:0]  q_a [$];
  logic [7:0]  q_b [$];
  logic [7:0]  q_c [$];
  logic [2:0]  prev_addr_a = 0;
  int          sel_cnt_c = 0;
  int          sel_run_c = 0;
  logic        rand_c = 0;
  logic        prev_stall_c = 0;
  logic [7:0]  prev_data_c = 0;

  sram_byte_streamer #(
    .DATA_W(16), .BYTE_W(8), .ADDR_W(3), .CNT_W(20), .TOTAL_BYTES(20),
    .PAUSE_WORDS(4), .RD_LAT(1), .MSB_FIRST(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .restart(restart_a), .resume(resume_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .sram_addr(sram_addr_a), .sram_sel(sram_sel_a), .sram_rd(sram_rd_a), .sram_wr(sram_wr_a),
    .sram_rdata(rdata_a), .pause(pause_a), .finish(finish_a), .byte_count(byte_count_a)
  );

  sram_byte_streamer #(
    .TOTAL_BYTES(5)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .restart(restart_b), .resume(resume_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .sram_addr(sram_addr_b), .sram_sel(sram_sel_b), .sram_rd(sram_rd_b), .sram_wr(sram_wr_b),
    .sram_rdata(rdata_b), .pause(pause_b), .finish(finish_b), .byte_count(byte_count_b)
  );

  sram_byte_streamer #(
    .DATA_W(32), .RD_LAT(3), .MSB_FIRST(0), .PAUSE_WORDS(0)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .restart(restart_c), .resume(resume_c),
    .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .sram_addr(sram_addr_c), .sram_sel(sram_sel_c), .sram_rd(sram_rd_c), .sram_wr(sram_wr_c),
    .sram_rdata(rdata_c), .pause(pause_c), .finish(finish_c), .byte_count(byte_count_c)
  );

  // Little-endian image: stream byte k is k ^ 8'hC3.
  function automatic logic [31:0] img_c(input logic [18:0] a);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(32'(a) * 32'd4 + 32'(j)) ^ 8'hC3;
    return w;
  endfunction

  // SRAM models: data is only valid once select has been held RD_LAT cycles.
  assign rdata_a = sram_sel_a ? mem_a[sram_addr_a] : 16'hDEAD;
  assign rdata_b = sram_sel_b ? mem_a[sram_addr_b[2:0]] : 16'hDEAD;
  assign rdata_c = (sram_sel_c && sel_cnt_c == 2) ? img_c(sram_addr_c) : 32'hDEADBEEF;

  always @(posedge clk) sel_cnt_c <= sram_sel_c ? sel_cnt_c + 1 : 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_c) out_ready_c = 1'($urandom_range(0, 1));
    end
  end

  // Monitor A: byte scoreboard and address stepping (wrap included).
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid_a && out_ready_a) begin
        if (q_a.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL a_extra_byte: got %0h with no byte expected", out_data_a);
        end else check("a_byte", 32'(out_data_a), 32'(q_a.pop_front()));
      end
      if (sram_addr_a != prev_addr_a) begin
        check("a_addr_step", 32'(sram_addr_a),
              (byte_count_a == 0) ? 32'd0 : 32'(3'(prev_addr_a + 3'd1)));
        prev_addr_a = sram_addr_a;
      end
    end
  end

  // Monitor B: byte scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid_b && out_ready_b) begin
        if (q_b.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL b_extra_byte: got %0h with no byte expected", out_data_b);
        end else check("b_byte", 32'(out_data_b), 32'(q_b.pop_front()));
      end
    end
  end

  // Monitor C: byte scoreboard, hold-under-stall and read strobe length.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_stall_c) begin
        check("c_hold_valid", 32'(out_valid_c), 32'd1);
        check("c_hold_data", 32'(out_data_c), 32'(prev_data_c));
      end
      if (out_valid_c && out_ready_c) begin
        if (q_c.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL c_extra_byte: got %0h with no byte expected", out_data_c);
        end else check("c_byte", 32'(out_data_c), 32'(q_c.pop_front()));
      end
      prev_stall_c = out_valid_c && !out_ready_c;
      prev_data_c  = out_data_c;
      if (sram_sel_c) sel_run_c++;
      else if (sel_run_c != 0) begin
        check("c_sel_len", 32'(sel_run_c), 32'd3);
        sel_run_c = 0;
      end
    end
  end

  initial begin
    mem_a[0] = 16'hA0B1; mem_a[1] = 16'hC2D3; mem_a[2] = 16'hE4F5; mem_a[3] = 16'h0617;
    mem_a[4] = 16'h2839; mem_a[5] = 16'h4A5B; mem_a[6] = 16'h6C7D; mem_a[7] = 16'h8E9F;

    // ---- reset values
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_data", 32'(out_data_a), 0);
    check("rst_a_valid", 32'(out_valid_a), 0);
    check("rst_a_addr", 32'(sram_addr_a), 0);
    check("rst_a_sel", 32'({sram_sel_a, sram_rd_a, sram_wr_a}), 0);
    check("rst_a_flags", 32'({pause_a, finish_a}), 0);
    check("rst_a_count", 32'(byte_count_a), 0);
    check("rst_b_outs", 32'({out_valid_b, sram_sel_b, sram_rd_b, sram_wr_b, pause_b, finish_b}), 0);
    check("rst_c_outs", 32'({out_valid_c, sram_sel_c, sram_rd_c, sram_wr_c, pause_c, finish_c}), 0);
    check("rst_c_data", 32'(out_data_c), 0);
    @(posedge clk); #1 rst_n = 1;

    // ---- A: latency, throughput, pauses, address wrap, finish, restart
    for (int w = 0; w < 10; w++) begin
      q_a.push_back(mem_a[w % 8][15:8]);
      q_a.push_back(mem_a[w % 8][7:0]);
    end
    out_ready_a = 1;
    @(posedge clk); #1 start_a = 1;
    @(negedge clk);
    check("a_lat_t0_sel", 32'(sram_sel_a), 0);
    @(negedge clk);
    check("a_lat_t1_sel", 32'({sram_sel_a, sram_rd_a}), 32'h3);
    check("a_lat_t1_valid", 32'(out_valid_a), 0);
    @(negedge clk);
    check("a_lat_t2_valid", 32'(out_valid_a), 1);
    check("a_lat_t2_sel", 32'(sram_sel_a), 0);
    check("a_lat_t2_data", 32'(out_data_a), 32'hA0);
    @(negedge clk);
    check("a_t3_data", 32'(out_data_a), 32'hB1);
    @(negedge clk);
    check("a_t4_sel", 32'(sram_sel_a), 1);
    check("a_t4_addr", 32'(sram_addr_a), 1);

    for (int i = 0; i < 100 && !pause_a; i++) @(negedge clk);
    check("a_pause1", 32'(pause_a), 1);
    check("a_pause1_addr", 32'(sram_addr_a), 4);
    check("a_pause1_count", 32'(byte_count_a), 8);
    repeat (3) @(negedge clk);
    check("a_pause1_idle", 32'({sram_sel_a, out_valid_a, pause_a}), 32'h1);
    @(posedge clk); #1 resume_a = 1;
    @(negedge clk);
    check("a_resume_t0_sel", 32'(sram_sel_a), 0);
    @(posedge clk); #1 resume_a = 0;
    @(negedge clk);
    check("a_resume_t1_sel", 32'(sram_sel_a), 1);
    check("a_resume_t1_pause", 32'(pause_a), 0);

    for (int i = 0; i < 100 && !pause_a; i++) @(negedge clk);
    check("a_pause2", 32'(pause_a), 1);
    check("a_pause2_addr", 32'(sram_addr_a), 0);
    check("a_pause2_count", 32'(byte_count_a), 16);
    @(posedge clk); #1 resume_a = 1;
    @(posedge clk); #1 resume_a = 0;

    for (int i = 0; i < 100 && !finish_a; i++) @(negedge clk);
    check("a_finish", 32'(finish_a), 1);
    check("a_finish_count", 32'(byte_count_a), 20);
    check("a_finish_addr", 32'(sram_addr_a), 1);
    check("a_finish_valid", 32'(out_valid_a), 0);
    check("a_queue_empty", 32'(q_a.size()), 0);
    repeat (3) @(negedge clk);
    check("a_finish_hold", 32'({finish_a, sram_sel_a, out_valid_a}), 32'h4);
    @(posedge clk); #1 begin start_a = 0; restart_a = 1; end
    @(posedge clk); #1 restart_a = 0;
    @(negedge clk);
    check("a_restart_addr", 32'(sram_addr_a), 0);
    check("a_restart_count", 32'(byte_count_a), 0);
    check("a_restart_flags", 32'({finish_a, out_valid_a, sram_sel_a}), 0);

    // ---- B: mid-word finish, restart, restart colliding with last-lane accept
    q_b.push_back(8'hA0); q_b.push_back(8'hB1);
    q_b.push_back(8'hC2); q_b.push_back(8'hD3);
    q_b.push_back(8'hE4);
    out_ready_b = 1;
    @(posedge clk); #1 start_b = 1;
    for (int i = 0; i < 100 && !finish_b; i++) @(negedge clk);
    check("b_finish", 32'(finish_b), 1);
    check("b_finish_count", 32'(byte_count_b), 5);
    check("b_finish_addr", 32'(sram_addr_b), 2);
    check("b_finish_valid", 32'(out_valid_b), 0);
    check("b_queue_empty", 32'(q_b.size()), 0);
    @(posedge clk); #1 begin start_b = 0; restart_b = 1; end
    @(posedge clk); #1 restart_b = 0;
    @(negedge clk);
    check("b_restart_state", 32'({finish_b, out_valid_b, sram_sel_b}), 0);
    check("b_restart_count", 32'(byte_count_b), 0);
    check("b_restart_addr", 32'(sram_addr_b), 0);

    out_ready_b = 0;
    q_b.push_back(8'hA0); q_b.push_back(8'hB1);
    @(posedge clk); #1 start_b = 1;
    for (int i = 0; i < 20 && !out_valid_b; i++) @(negedge clk);
    check("b_valid_wait", 32'(out_valid_b), 1);
    @(posedge clk); #1 out_ready_b = 1;
    @(posedge clk); #1 out_ready_b = 0;
    @(negedge clk);
    check("b_lane1_count", 32'(byte_count_b), 1);
    check("b_lane1_data", 32'(out_data_b), 32'hB1);
    @(posedge clk); #1 begin out_ready_b = 1; restart_b = 1; end
    @(posedge clk); #1 begin out_ready_b = 0; restart_b = 0; start_b = 0; end
    @(negedge clk);
    check("b_collide_count", 32'(byte_count_b), 0);
    check("b_collide_addr", 32'(sram_addr_b), 0);
    check("b_collide_valid", 32'(out_valid_b), 0);
    check("b_queue_empty2", 32'(q_b.size()), 0);

    // ---- C: 32-bit LSB-first stream under random backpressure
    for (int k = 0; k < 40; k++) q_c.push_back(8'(k) ^ 8'hC3);
    rand_c = 1;
    @(posedge clk); #1 start_c = 1;
    for (int i = 0; i < 2000 && byte_count_c != 20'd36; i++) @(negedge clk);
    check("c_count36", 32'(byte_count_c), 36);
    @(posedge clk); #1 start_c = 0;
    for (int i = 0; i < 500 && byte_count_c != 20'd40; i++) @(negedge clk);
    check("c_count40", 32'(byte_count_c), 40);
    rand_c = 0;
    repeat (6) @(negedge clk);
    check("c_idle", 32'({out_valid_c, sram_sel_c}), 0);
    check("c_final_count", 32'(byte_count_c), 40);
    check("c_final_addr", 32'(sram_addr_c), 10);
    check("c_queue_empty", 32'(q_c.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
